// File: rtl/patbuf_pkg.sv
// patbuf_pkg: shared FSM encoding and size helpers for the pattern buffer.
package patbuf_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int total_bits(input int w, input int d);
    return w * d;
  endfunction
  function automatic int cnt_width(input int w, input int d);
    return $clog2(w * d + 1);
  endfunction
endpackage

// File: rtl/patbuf_shift_chain.sv
// patbuf_shift_chain: shadow bank as one flat serial shift register, word 0 nearest sin.
module patbuf_shift_chain
  import patbuf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 27
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     sin,
  output logic                     sout,
  output logic [WIDTH*DEPTH-1:0]   shadow_flat
);
  localparam int TOTAL = total_bits(WIDTH, DEPTH);
  // Word i occupies bits [i*WIDTH +: WIDTH], so the word-to-word carry is a plain left shift.
  always_ff @(posedge sclk) begin
    if (rst) shadow_flat <= '0;
    else if (shift_en) shadow_flat <= {shadow_flat[TOTAL-2:0], sin};
  end
  assign sout = shadow_flat[TOTAL-1];
endmodule

// File: rtl/patbuf_shadow.sv
// patbuf_shadow: serially loaded shadow bank committed atomically to a readable active bank.
// Optional PATBUF_LOCK_EN adds a lock input that vetoes commits.
module patbuf_shadow
  import patbuf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 27,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             sclk,
  input  logic             rst,
`ifdef PATBUF_LOCK_EN
  input  logic             lock,
`endif
  input  logic             ssel,
  input  logic             sin,
  output logic             sout,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             commit_ok,
  output logic             load_err,
  input  logic             err_clr
);
  localparam int TOTAL = total_bits(WIDTH, DEPTH);
  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] FULL = CW'(TOTAL);
  localparam logic [CW-1:0] SAT = CW'(TOTAL + 1);
  logic [TOTAL-1:0] shadow_flat;
  logic [WIDTH-1:0] active [DEPTH];
  logic [CW-1:0] bit_cnt;
  state_t state, state_n;
  logic locked, end_load, do_commit;
`ifdef PATBUF_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif
  patbuf_shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chain (
    .sclk(sclk),
    .rst(rst),
    .shift_en(ssel),
    .sin(sin),
    .sout(sout),
    .shadow_flat(shadow_flat)
  );
  always_comb begin
    state_n = ssel ? ST_SHIFT : ST_IDLE;
    end_load = (state == ST_SHIFT) && !ssel;
    do_commit = end_load && (bit_cnt == FULL) && !locked;
  end
  always_ff @(posedge sclk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      bit_cnt <= '0;
      commit_ok <= 1'b0;
      load_err <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) active[i] <= '0;
    end else begin
      bit_cnt <= end_load ? '0 : (ssel && bit_cnt != SAT) ? bit_cnt + 1'b1 : bit_cnt;
      commit_ok <= do_commit;
      load_err <= (end_load && !do_commit) || (load_err && !err_clr);
      rd_data <= ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) ? active[rd_addr] : '0;
      if (do_commit)
        for (int i = 0; i < DEPTH; i++) active[i] <= shadow_flat[i*WIDTH +: WIDTH];
    end
  end
endmodule

// File: tb/tb_patbuf_shadow.sv
// tb_patbuf_shadow: table-driven load/commit/error checks plus hand sequences for replay, reset and commit-edge reads.
module tb_patbuf_shadow;
  logic sclk = 1'b0;
  logic rst, lock, ssel, sin, err_clr, sout, commit_ok, load_err;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  int total = 0;
  int passed = 0;

  always #5 sclk = ~sclk;

  patbuf_shadow #(.WIDTH(8), .DEPTH(4)) dut (
    .sclk(sclk),
    .rst(rst),
`ifdef PATBUF_LOCK_EN
    .lock(lock),
`endif
    .ssel(ssel),
    .sin(sin),
    .sout(sout),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .commit_ok(commit_ok),
    .load_err(load_err),
    .err_clr(err_clr)
  );

  typedef struct {
    logic        pre_clr;
    int          nbits;
    logic [63:0] pat;
    logic        clr_end;
    logic        lk;
    logic        exp_commit;
    logic        exp_err;
    logic [31:0] exp_active;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Shifts n bits of pat MSB first, then drops ssel; returns at #1 after the end-of-load edge.
  task automatic do_load(input logic [63:0] pat, input int n, input logic clr_end,
                         input logic lk, output int pulses);
    pulses = 0;
    lock = lk;
    for (int i = n - 1; i >= 0; i--) begin
      ssel = 1'b1;
      sin = pat[i];
      tick();
      if (commit_ok) pulses++;
    end
    ssel = 1'b0;
    sin = 1'b0;
    err_clr = clr_end;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic read_all(input string nm, input logic [31:0] exp);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      tick();
      chk($sformatf("%s_rd%0d", nm, a), 32'(rd_data), 32'(exp[a*8 +: 8]));
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] replay;
    tbl[0] = '{1'b0, 32, 64'hA1B2C3D4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA1B2C3D4};
    tbl[1] = '{1'b0, 31, 64'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4};
    tbl[2] = '{1'b1, 33, 64'h1DEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4};
    tbl[3] = '{1'b1, 33, 64'h1DEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4};
    tbl[4] = '{1'b1, 32, 64'h5A6B7C8D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5A6B7C8D};
`ifdef PATBUF_LOCK_EN
    tbl[5] = '{1'b0, 32, 64'h11223344, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5A6B7C8D};
`else
    tbl[5] = '{1'b0, 32, 64'h11223344, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11223344};
`endif
    tbl[6] = '{1'b1, 32, 64'h11223344, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11223344};

    rst = 1'b1; lock = 1'b0; ssel = 1'b0; sin = 1'b0; err_clr = 1'b0; rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_commit", 32'(commit_ok), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_sout", 32'(sout), 0);
    read_all("rst", 32'h0);

    for (int k = 0; k < 7; k++) begin
      if (tbl[k].pre_clr) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk($sformatf("t%0d_clr", k), 32'(load_err), 0);
      end
      do_load(tbl[k].pat, tbl[k].nbits, tbl[k].clr_end, tbl[k].lk, pulses);
      lock = 1'b0;
      chk($sformatf("t%0d_early", k), pulses, 0);
      chk($sformatf("t%0d_commit", k), 32'(commit_ok), 32'(tbl[k].exp_commit));
      chk($sformatf("t%0d_err", k), 32'(load_err), 32'(tbl[k].exp_err));
      tick();
      chk($sformatf("t%0d_pulse_end", k), 32'(commit_ok), 0);
      read_all($sformatf("t%0d", k), tbl[k].exp_active);
    end

    // sout replays the previously loaded stream while a new load shifts in.
    rd_addr = 2'd0;
    replay = '0;
    for (int i = 31; i >= 0; i--) begin
      replay = {replay[30:0], sout};
      ssel = 1'b1;
      sin = 32'hCAFEF00D >> i;
      tick();
    end
    chk("replay_sout", replay, 32'h11223344);
    ssel = 1'b0;
    tick();
    chk("edge_commit", 32'(commit_ok), 1);
    chk("edge_rd_old", 32'(rd_data), 32'h44);
    tick();
    chk("edge_rd_new", 32'(rd_data), 32'h0D);
    chk("edge_pulse_end", 32'(commit_ok), 0);

    // Reset halfway through a load: no commit, no error, counter restarts.
    for (int i = 0; i < 16; i++) begin
      ssel = 1'b1;
      sin = i[0];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ssel = 1'b0;
    tick();
    chk("midrst_commit", 32'(commit_ok), 0);
    chk("midrst_err", 32'(load_err), 0);
    read_all("midrst", 32'h0);
    do_load(64'h0F1E2D3C, 32, 1'b0, 1'b0, pulses);
    chk("after_rst_commit", 32'(commit_ok), 1);
    chk("after_rst_err", 32'(load_err), 0);
    read_all("after_rst", 32'h0F1E2D3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
